// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: ASCII command stream from a UART receiver driving a register bus.
// Ports: rx_* byte in (valid/ready), tx_* byte out (valid/ready), bus_* register bus, rd_timeout pulse.
module uart_bus_bridge #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 15,
  parameter bit AUTO_INC   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic              rd_timeout
);

  localparam int W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int NA = (ADDR_W + 7) / 8;
  localparam int ND = DATA_W / 8;
  localparam int AB = NA * 8;
  localparam int SW = (AB > DATA_W) ? AB : DATA_W;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int BW = $clog2(SW / 8 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_TX
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      x_q, x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              to_q, to_d;
  logic              inc_q, inc_d;
  logic              rd_q, rd_d;
  logic              tv_q, tv_d;
  logic              rdy_q;
  logic [SW-1:0]     sh_q, sh_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              acc;
  logic              hex_ok;
  logic [3:0]        nib;

  assign acc = rx_valid & rdy_q;

  always_comb begin
    hex_ok = 1'b0;
    nib    = 4'd0;
    unique case (1'b1)
      (rx_data >= 8'h30 && rx_data <= 8'h39): begin
        hex_ok = 1'b1;
        nib    = rx_data[3:0];
      end
      (rx_data >= 8'h61 && rx_data <= 8'h66),
      (rx_data >= 8'h41 && rx_data <= 8'h46): begin
        hex_ok = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    to_d    = 1'b0;
    inc_d   = inc_q;
    rd_d    = rd_q;
    tv_d    = tv_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    // Post-write increment lands one cycle after the strobe;
    // an 'm' accepted in that same cycle overrides it below.
    if (we_q && inc_q) addr_d = addr_q + ADDR_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (hex_ok) begin
            x_d = {x_q[W-5:0], nib};
          end else begin
            case (rx_data)
              8'h6d: begin
                addr_d = x_q[ADDR_W-1:0];
                x_d    = '0;
              end
              8'h77: begin
                wd_d = x_q[DATA_W-1:0];
                we_d = 1'b1;
                x_d  = '0;
              end
              8'h72: begin
                re_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_RD;
              end
              8'h78: begin
                sh_d              = '0;
                sh_d[SW-1 -: AB]  = AB'(addr_q);
                cnt_d             = BW'(NA);
                tv_d              = 1'b1;
                rd_d              = 1'b0;
                state_d           = S_TX;
              end
              8'h2b: inc_d = 1'b1;
              8'h2d: inc_d = 1'b0;
              default: ;
            endcase
          end
        end
      end
      S_RD: begin
        // The strobe cycle itself is not sampled.
        if (!re_q) begin
          if (bus_rvalid || tmo_q == TW'(RD_TIMEOUT - 1)) begin
            sh_d                 = '0;
            sh_d[SW-1 -: DATA_W] = bus_rvalid ? bus_rdata : '1;
            to_d                 = !bus_rvalid;
            cnt_d                = BW'(ND);
            tv_d                 = 1'b1;
            rd_d                 = 1'b1;
            state_d              = S_TX;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_TX: begin
        if (tv_q && tx_ready) begin
          if (cnt_q == BW'(1)) begin
            tv_d    = 1'b0;
            state_d = S_IDLE;
            if (rd_q && inc_q) addr_d = addr_q + ADDR_W'(1);
          end else begin
            sh_d  = sh_q << 8;
            cnt_d = cnt_q - BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      to_q    <= 1'b0;
      inc_q   <= AUTO_INC;
      rd_q    <= 1'b0;
      tv_q    <= 1'b0;
      rdy_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      re_q    <= re_d;
      to_q    <= to_d;
      inc_q   <= inc_d;
      rd_q    <= rd_d;
      tv_q    <= tv_d;
      rdy_q   <= (state_d == S_IDLE);
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rx_ready   = rdy_q;
  assign tx_data    = sh_q[SW-1 -: 8];
  assign tx_valid   = tv_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wd_q;
  assign bus_we     = we_q;
  assign bus_re     = re_q;
  assign rd_timeout = to_q;

endmodule
